// File: rtl/note_sequencer.sv
// note_sequencer: plays a three-voice song ROM entry by entry, timing each note in
// programmable tempo ticks with an optional silent gap between entries.
module note_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DUR_W     = 9,
    parameter int TICK_W    = 24,
    parameter int GAP_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [TICK_W-1:0]     tick_period,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [27+DUR_W-1:0]   mem_data,
    output logic [26:0]           notes,
    output logic                  busy,
    output logic                  song_done
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP} state_t;
    state_t state, state_nx;
    logic [TICK_W-1:0] tick_cnt, period, p_new;
    logic [DUR_W-1:0] dur_cnt, dur;
    logic tick_last, phase_end, load_play, load_gap;

    assign busy = state != IDLE;

    always_comb begin
        dur = mem_data[27 +: DUR_W];
        p_new = (tick_period == '0) ? TICK_W'(1) : tick_period;
        tick_last = tick_cnt == period - TICK_W'(1);
        phase_end = tick_last && dur_cnt == DUR_W'(1);
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = (dur != '0) ? PLAY : loop_en ? FETCH : IDLE;
            PLAY:    state_nx = phase_end ? ((GAP_TICKS > 0) ? GAP : FETCH) : PLAY;
            GAP:     state_nx = phase_end ? FETCH : GAP;
            default: state_nx = IDLE;
        endcase
        // start restarts from any state; stop overrides everything
        if (start) state_nx = FETCH;
        if (stop) state_nx = IDLE;
        load_play = state == WAIT && state_nx == PLAY;
        load_gap = state == PLAY && state_nx == GAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            notes     <= '0;
            song_done <= 1'b0;
            tick_cnt  <= '0;
            period    <= '0;
            dur_cnt   <= '0;
        end else begin
            state     <= state_nx;
            mem_en    <= state_nx == FETCH;
            song_done <= state == WAIT && state_nx == IDLE && !stop;
            notes     <= (state_nx == IDLE || load_gap) ? '0 : load_play ? mem_data[26:0] : notes;
            mem_addr  <= stop ? mem_addr
                       : (start || (state == WAIT && state_nx == FETCH)) ? '0
                       : (state == PLAY && phase_end) ? mem_addr + ADDR_W'(1) : mem_addr;
            if (load_play || load_gap) begin
                tick_cnt <= '0;
                period   <= p_new;
                dur_cnt  <= load_play ? dur : DUR_W'(GAP_TICKS);
            end else if (state == PLAY || state == GAP) begin
                tick_cnt <= tick_last ? '0 : tick_cnt + TICK_W'(1);
                dur_cnt  <= tick_last ? dur_cnt - DUR_W'(1) : dur_cnt;
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: drives a gapless and a one-tick-gap sequencer side by side and
// compares every cycle against a timeline built from entry durations.
module tb_note_sequencer;
    localparam int AW = 2, DW = 9, TW = 24, MAXL = 200;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [TW-1:0] tick_period = '0;
    logic [1:0] me, bz, sd;
    logic [1:0][AW-1:0] ma;
    logic [1:0][26:0] nt;
    logic [1:0][27+DW-1:0] md;
    logic [27+DW-1:0] rom [4];
    int tps [MAXL+1];
    logic [26:0] en [2][MAXL+1];
    logic eb [2][MAXL+1];
    logic ee [2][MAXL+1];
    logic ed [2][MAXL+1];
    int ea [2][MAXL+1];
    logic [26:0] cur_n [2];
    int checks = 0, errors = 0;

    note_sequencer #(.ADDR_W(AW), .DUR_W(DW), .TICK_W(TW), .GAP_TICKS(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .tick_period(tick_period), .mem_en(me[0]), .mem_addr(ma[0]), .mem_data(md[0]),
        .notes(nt[0]), .busy(bz[0]), .song_done(sd[0]));
    note_sequencer #(.ADDR_W(AW), .DUR_W(DW), .TICK_W(TW), .GAP_TICKS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .tick_period(tick_period), .mem_en(me[1]), .mem_addr(ma[1]), .mem_data(md[1]),
        .notes(nt[1]), .busy(bz[1]), .song_done(sd[1]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (me[0]) md[0] <= rom[ma[0]];
        if (me[1]) md[1] <= rom[ma[1]];
    end

    task automatic chk(string tag, int k, int c, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d observed %0h expected %0h", tag, k, c, obs, exp);
        end
    endtask

    task automatic put(int k, int j, logic [26:0] n, logic b, logic e, int a, logic d);
        en[k][j] = n; eb[k][j] = b; ee[k][j] = e; ea[k][j] = a; ed[k][j] = d;
    endtask

    // Timeline: each entry is FETCH, WAIT, dur*P notes, then k*P silent cycles (k = gap ticks)
    task automatic build(int k, int L, int stop_at, logic lp);
        int j, addr, dur, p;
        logic [26:0] cur;
        cur = cur_n[k]; addr = 0; j = 1;
        while (j <= L) begin
            put(k, j, cur, 1'b1, 1'b1, addr, 1'b0);
            j++;
            if (j > L) break;
            dur = int'(rom[addr][27 +: DW]);
            put(k, j, cur, 1'b1, 1'b0, addr, 1'b0);
            p = (tps[j] == 0) ? 1 : tps[j];
            j++;
            if (dur == 0) begin
                if (lp) begin
                    addr = 0;
                    continue;
                end
                if (j <= L) put(k, j, '0, 1'b0, 1'b0, 0, 1'b1);
                j++;
                break;
            end
            cur = rom[addr][26:0];
            for (int n = 0; n < dur * p && j <= L; n++) begin
                put(k, j, cur, 1'b1, 1'b0, addr, 1'b0);
                j++;
            end
            p = (tps[j-1] == 0) ? 1 : tps[j-1];
            addr = (addr + 1) % 4;
            if (k > 0) cur = '0;
            for (int n = 0; n < k * p && j <= L; n++) begin
                put(k, j, '0, 1'b1, 1'b0, addr, 1'b0);
                j++;
            end
        end
        while (j <= L) begin
            put(k, j, '0, 1'b0, 1'b0, 0, 1'b0);
            j++;
        end
        if (stop_at >= 0)
            for (int i = stop_at + 1; i <= L; i++) put(k, i, '0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic session(int L, int stop_at, logic lp);
        build(0, L, stop_at, lp);
        build(1, L, stop_at, lp);
        loop_en = lp; start = 1'b1; stop = (stop_at == 0); tick_period = TW'(tps[0]);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk("notes", k, c, 32'(nt[k]), 32'(en[k][c]));
                chk("busy", k, c, 32'(bz[k]), 32'(eb[k][c]));
                chk("mem_en", k, c, 32'(me[k]), 32'(ee[k][c]));
                chk("song_done", k, c, 32'(sd[k]), 32'(ed[k][c]));
                if (ee[k][c]) chk("mem_addr", k, c, 32'(ma[k]), 32'(ea[k][c]));
            end
            tick_period = TW'(tps[c]);
            stop = (c == stop_at);
        end
        stop = 1'b0;
        for (int k = 0; k < 2; k++) cur_n[k] = en[k][L];
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_notes", k, -1, 32'(nt[k]), 32'd0);
            chk("rst_mem_en", k, -1, 32'(me[k]), 32'd0);
            chk("rst_mem_addr", k, -1, 32'(ma[k]), 32'd0);
            chk("rst_busy", k, -1, 32'(bz[k]), 32'd0);
            chk("rst_song_done", k, -1, 32'(sd[k]), 32'd0);
        end
    endtask

    task automatic set_tps(int base, int from, int nv);
        for (int i = 0; i <= MAXL; i++) tps[i] = (i < from) ? base : nv;
    endtask

    initial begin
        int L, sa;
        cur_n[0] = '0; cur_n[1] = '0;
        for (int i = 0; i < 4; i++) rom[i] = '0;
        set_tps(4, 0, 4);
        #12;
        chk_reset();
        @(negedge clk); rst_n = 1'b1;
        // single note then marker
        rom[0] = {9'd3, 27'h0000005}; rom[1] = '0;
        session(24, -1, 1'b0);
        // stop mid-PLAY, then replay
        session(12, 8, 1'b0);
        session(24, -1, 1'b0);
        // tick_period 0 acts as 1
        rom[0] = {9'd2, 27'h0123456}; rom[1] = {9'd2, 27'h7000001}; rom[2] = '0;
        set_tps(0, 0, 0);
        session(12, -1, 1'b0);
        // period change mid-note only affects later phases
        rom[0] = {9'd2, 27'h00000AA}; rom[1] = {9'd1, 27'h5500000}; rom[2] = '0;
        set_tps(4, 6, 8);
        session(48, -1, 1'b0);
        // looping song, left running so the next start restarts it
        rom[0] = {9'd1, 27'h1111111}; rom[1] = {9'd2, 27'h2222222}; rom[2] = '0;
        set_tps(2, 0, 2);
        session(60, -1, 1'b1);
        // no marker: address wraps 0,1,2,3,0
        rom[0] = {9'd1, 27'h0000011}; rom[1] = {9'd1, 27'h0000022};
        rom[2] = {9'd1, 27'h0000033}; rom[3] = {9'd1, 27'h0000044};
        set_tps(1, 0, 1);
        session(50, 48, 1'b0);
        // start and stop together
        session(6, 0, 1'b0);
        repeat (15) begin
            for (int i = 0; i < 4; i++) rom[i] = {DW'($urandom_range(0, 3)), 27'($urandom)};
            set_tps(int'($urandom_range(0, 3)), int'($urandom_range(1, 60)), int'($urandom_range(0, 3)));
            L = int'($urandom_range(10, 90));
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            session(L, sa, 1'($urandom_range(0, 1)));
        end
        // asynchronous reset while the gap variant is silent between entries
        rom[0] = {9'd3, 27'h0000005}; rom[1] = '0;
        set_tps(4, 0, 4);
        session(16, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk); rst_n = 1'b1;
        cur_n[0] = '0; cur_n[1] = '0;
        session(24, -1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a three-voice song stored in a synchronous song ROM, one entry at a time, and drives the 27-bit `notes` bus of the note decoder. The decoder accepts this bus unchanged. Each ROM entry holds one `notes` word and a duration in tempo ticks. The block times each entry with a programmable tick period and inserts an optional silent articulation gap between entries. It supports start, stop and loop control from the user-interface logic.

## Interface
Parameters:
- ADDR_W, 8: song ROM address width.
- DUR_W, 9: duration field width, in ticks.
- TICK_W, 24: width of the tick period, in clk cycles.
- GAP_TICKS, 1: number of silent ticks after each note entry. 0 disables the gap.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse. Begins playback from address 0.
- stop  in  1  one-cycle pulse. Aborts playback.
- loop_en  in  1  level. At the end marker, playback restarts at address 0 instead of finishing.
- tick_period  in  TICK_W  clk cycles per tick. A value of 0 is treated as 1.
- mem_en  out  1  song ROM read enable.
- mem_addr  out  ADDR_W  song ROM address.
- mem_data  in  27+DUR_W  ROM entry, valid the cycle after mem_en.
  - [26:0] notes word. Voice v occupies bits [9v+8:9v]: [9v+6:9v] is the note index (0 = silent), [9v+8:9v+7] is the waveform select.
  - [27+DUR_W-1:27] duration. Duration 0 is the end-of-song marker.
- notes  out  27  registered note bus to the decoder.
- busy  out  1  high in every state except IDLE.
- song_done  out  1  one-cycle pulse when playback reaches the end marker and loop_en is 0.

## Operation
- FSM states: IDLE, FETCH, WAIT, PLAY, GAP.
- IDLE:
  - notes = 0, mem_en = 0.
  - On start: addr ← 0, go to FETCH.
- FETCH:
  - mem_en = 1, mem_addr = addr. Exactly one cycle.
  - Go to WAIT.
- WAIT: mem_data is valid this cycle.
  - Duration ≠ 0:
    - notes ← mem_data[26:0].
    - dur_cnt ← duration.
    - Latch P = max(tick_period, 1).
    - Clear tick_cnt. Go to PLAY.
  - Duration = 0 and loop_en = 1: addr ← 0, go to FETCH. notes holds its value.
  - Duration = 0 and loop_en = 0: notes ← 0, pulse song_done, go to IDLE.
- PLAY:
  - tick_cnt counts 0..P-1. At P-1 it wraps and dur_cnt decrements.
  - When the last tick completes (dur_cnt = 1 and tick_cnt = P-1):
    - addr ← addr + 1. Address wraps modulo 2^ADDR_W.
    - If GAP_TICKS > 0: notes ← 0, reload tick counting with a fresh P, go to GAP.
    - Otherwise go directly to FETCH.
- GAP:
  - notes = 0 for GAP_TICKS·P cycles, then go to FETCH.
- When GAP_TICKS = 0, notes holds the previous entry through FETCH/WAIT. The bus changes only at entry boundaries, never to a transient 0.
- stop:
  - From any state: next state is IDLE and notes ← 0.
  - No song_done pulse.
  - An outstanding ROM read is discarded.
- start while busy restarts from address 0 immediately: go to FETCH, notes holds its value until the WAIT load.
- start and stop in the same cycle: stop wins.
- tick_period changes affect only the next PLAY/GAP entry. The running phase keeps its latched P.
- Reset: state = IDLE; notes = 0; mem_en = 0; mem_addr = 0; busy = 0; song_done = 0; all counters = 0. Reset takes effect mid-operation asynchronously.

## Timing
- All outputs are registered except busy, which decodes from the state register.
- start sampled at edge 0:
  - FETCH at cycle 1: mem_en = 1, mem_addr = 0.
  - WAIT at cycle 2.
  - New notes visible from cycle 3, the first PLAY cycle.
- Each non-marker entry occupies exactly 2 + dur·P + GAP_TICKS·P cycles.
- The end marker costs 2 cycles: FETCH + WAIT. song_done asserts in the cycle after WAIT, together with busy = 0.
- The loop restart adds 2 cycles for the marker fetch before address 0 is fetched.
- The ROM read latency is fixed at 1. The block never issues back-to-back reads.

## Test plan
- Single note: ROM[0] = {dur=3, notes=0x0000005}, ROM[1] = marker, P = 4, GAP_TICKS = 0, start.
  - Expect notes = 0x0000005 for cycles 3..14.
  - Then notes = 0x0000005 held through FETCH/WAIT of entry 1 (cycles 15-16).
  - song_done pulse at cycle 17, busy = 0 from cycle 17, notes = 0 from cycle 17.
- Gap: same ROM, GAP_TICKS = 1, P = 4.
  - Expect notes = 0 for cycles 15..18.
  - Marker fetch at cycles 19-20, song_done at cycle 21.
- Loop: 2 entries + marker, loop_en = 1.
  - After the marker, mem_addr = 0 is fetched 2 cycles later.
  - No song_done across 3 loops.
- Stop mid-PLAY at cycle 8: notes = 0 and busy = 0 at cycle 9, no song_done.
  - A later start replays from address 0 with the same cycle timing.
- tick_period = 0 with dur = 2: the note lasts exactly 2 cycles.
  - Change tick_period mid-note from 4 to 8: the current note keeps P = 4, the next note uses 8.
- Address wrap with ADDR_W = 2 and no marker: addresses fetched 0,1,2,3,0,…
  - Also verify that start and stop in the same cycle leaves the block in IDLE.
  - Also verify that rst_n asserted during GAP forces all outputs to their reset values immediately.
